// File: rtl/pong_pkg.sv
// Purpose: shared coordinate types, screen geometry and renderer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pong_pkg;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t H_ACTIVE = coord_t'(640);
  localparam coord_t V_ACTIVE = coord_t'(480);

  typedef enum logic {
    S_NOPOS = 1'b0,
    S_SHOW  = 1'b1
  } render_state_t;

endpackage

// File: rtl/ball_hit_pipe.sv
// Purpose: 2-stage hit test of the scan position against the ball centre.
// Latency: 2 clk from hcount/vcount to ball_pix/ball_rgb.
// Backpressure: none; advances every clk.
//
// Ports: clk/rst (async active-low), hcount/vcount scan position,
// shadow_x/shadow_y ball centre, enable (a position is being shown),
// ball_pix/ball_rgb registered hit flag and colour.
module ball_hit_pipe
  import pong_pkg::*;
#(
  parameter int          RADIUS   = 4,
  parameter logic [11:0] BALL_RGB = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  coord_t      hcount,
  input  coord_t      vcount,
  input  coord_t      shadow_x,
  input  coord_t      shadow_y,
  input  logic        enable,
  output logic        ball_pix,
  output logic [11:0] ball_rgb
);

  // Sum width leaves headroom so the squared distance never wraps.
  localparam int SUM_W = 2*COORD_W + 3;
  localparam logic [SUM_W-1:0] R2 = SUM_W'(RADIUS*RADIUS);

  logic signed [COORD_W:0] dx_d, dy_d, dx_q, dy_q;
  logic                    act_d, act_q;

  assign dx_d  = $signed({1'b0, hcount}) - $signed({1'b0, shadow_x});
  assign dy_d  = $signed({1'b0, vcount}) - $signed({1'b0, shadow_y});
  // Off-screen pixels never light, so partially visible balls clip for free.
  assign act_d = enable && (hcount < H_ACTIVE) && (vcount < V_ACTIVE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dx_q  <= '0;
      dy_q  <= '0;
      act_q <= 1'b0;
    end else begin
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      act_q <= act_d;
    end
  end

  logic signed [SUM_W-1:0] dx_e, dy_e, sq_sum;
  logic                    hit;

  assign dx_e   = dx_q;
  assign dy_e   = dy_q;
  assign sq_sum = dx_e*dx_e + dy_e*dy_e;
  assign hit    = act_q && ($unsigned(sq_sum) <= R2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ball_pix <= 1'b0;
      ball_rgb <= '0;
    end else begin
      ball_pix <= hit;
      ball_rgb <= hit ? BALL_RGB : 12'h000;
    end
  end

endmodule

// File: rtl/ball_renderer.sv
// Purpose: capture ball position, latch it at the frame boundary, draw the ball.
// Latency: pos_ack/frame_tick 1 clk; ball_pix/ball_rgb 2 clk from scan counters.
// Backpressure: none; every pos_valid is accepted and acked, last write wins.
//
// Ports: clk/rst (async active-low), hcount/vcount scan counters,
// ball_x/ball_y/pos_valid position input, pos_ack capture pulse,
// frame_tick boundary pulse, ball_pix/ball_rgb pixel output.
module ball_renderer
  import pong_pkg::*;
#(
  parameter int          RADIUS   = 4,
  parameter logic [11:0] BALL_RGB = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  coord_t      hcount,
  input  coord_t      vcount,
  input  coord_t      ball_x,
  input  coord_t      ball_y,
  input  logic        pos_valid,
  output logic        pos_ack,
  output logic        frame_tick,
  output logic        ball_pix,
  output logic [11:0] ball_rgb
);

  render_state_t state;
  coord_t        pend_x, pend_y;
  coord_t        shadow_x, shadow_y;
  logic          pend_full;
  logic          boundary;

  // Boundary sits in vertical blank, so a shadow swap here never tears.
  assign boundary = (hcount == '0) && (vcount == V_ACTIVE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_NOPOS;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_full  <= 1'b0;
      shadow_x   <= '0;
      shadow_y   <= '0;
      pos_ack    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      pos_ack    <= pos_valid;
      frame_tick <= boundary;

      // Shadow takes the pending value from before this cycle; a position
      // arriving on the boundary cycle itself waits for the next frame.
      if (boundary && pend_full) begin
        shadow_x  <= pend_x;
        shadow_y  <= pend_y;
        pend_full <= 1'b0;
      end

      if (pos_valid) begin
        pend_x    <= ball_x;
        pend_y    <= ball_y;
        pend_full <= 1'b1;
      end

      case (state)
        S_NOPOS: if (boundary && pend_full) state <= S_SHOW;
        S_SHOW:  state <= S_SHOW;
        default: state <= S_NOPOS;
      endcase
    end
  end

  ball_hit_pipe #(
    .RADIUS   (RADIUS),
    .BALL_RGB (BALL_RGB)
  ) u_hit (
    .clk      (clk),
    .rst      (rst),
    .hcount   (hcount),
    .vcount   (vcount),
    .shadow_x (shadow_x),
    .shadow_y (shadow_y),
    .enable   (state == S_SHOW),
    .ball_pix (ball_pix),
    .ball_rgb (ball_rgb)
  );

endmodule

// File: tb/tb_ball_renderer.sv
// Purpose: self-checking bench for ball_renderer against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ball_renderer;
  import pong_pkg::*;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst;
  coord_t      hcount, vcount, ball_x, ball_y;
  logic        pos_valid;
  logic        pos_ack, frame_tick, ball_pix;
  logic [11:0] ball_rgb;

  int checks = 0;
  int errors = 0;
  int lit_cnt = 0;
  int tick_cnt = 0;

  // Reference model: pending/shown positions as plain integers.
  int sx = 0, sy = 0, px = 0, py = 0;
  bit pf = 0, show = 0;
  bit pipe_q = 0, exp_pix = 0, exp_ack = 0, exp_tick = 0;

  ball_renderer #(.RADIUS(R), .BALL_RGB(12'hFFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .hcount     (hcount),
    .vcount     (vcount),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .pos_valid  (pos_valid),
    .pos_ack    (pos_ack),
    .frame_tick (frame_tick),
    .ball_pix   (ball_pix),
    .ball_rgb   (ball_rgb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sx = 0; sy = 0; px = 0; py = 0;
    pf = 0; show = 0; pipe_q = 0;
  endtask

  task automatic tick(input int h, input int v, input bit pv, input int bx, input int by);
    bit lit, bnd;
    int dx, dy;
    hcount = coord_t'(h); vcount = coord_t'(v);
    pos_valid = pv; ball_x = coord_t'(bx); ball_y = coord_t'(by);
    dx  = h - sx;
    dy  = v - sy;
    lit = show && (h < 640) && (v < 480) && (dx*dx + dy*dy <= R*R);
    bnd = (h == 0) && (v == 480);
    if (bnd && pf) begin sx = px; sy = py; show = 1; pf = 0; end
    if (pv) begin px = bx; py = by; pf = 1; end
    exp_pix  = pipe_q;
    pipe_q   = lit;
    exp_ack  = pv;
    exp_tick = bnd;
    @(posedge clk); #1;
    chk("pos_ack",    32'(pos_ack),    32'(exp_ack));
    chk("frame_tick", 32'(frame_tick), 32'(exp_tick));
    chk("ball_pix",   32'(ball_pix),   32'(exp_pix));
    chk("ball_rgb",   32'(ball_rgb),   exp_pix ? 32'hFFF : 32'h0);
    if (ball_pix === 1'b1) lit_cnt++;
    if (frame_tick === 1'b1) tick_cnt++;
  endtask

  task automatic idle();
    tick(700, 10, 0, 0, 0);
  endtask

  task automatic boundary(input bit pv = 0, input int bx = 0, input int by = 0);
    tick(0, 480, pv, bx, by);
  endtask

  // Scan a 13x13 patch around (cx,cy); exp_cnt < 0 skips the lit-count check.
  task automatic window(input int cx, input int cy, input int exp_cnt);
    idle(); idle();
    lit_cnt = 0;
    for (int v = cy - 6; v <= cy + 6; v++)
      for (int h = cx - 6; h <= cx + 6; h++)
        if (h >= 0 && h < 1024 && v >= 0 && v < 1024) tick(h, v, 0, 0, 0);
    idle(); idle();
    if (exp_cnt >= 0) chk($sformatf("lit_count(%0d,%0d)", cx, cy), 32'(lit_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int x, y, n;
    rst = 1'b0; hcount = '0; vcount = '0; ball_x = '0; ball_y = '0; pos_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pos_ack",    32'(pos_ack),    32'h0);
    chk("rst_frame_tick", 32'(frame_tick), 32'h0);
    chk("rst_ball_pix",   32'(ball_pix),   32'h0);
    chk("rst_ball_rgb",   32'(ball_rgb),   32'h0);
    @(negedge clk) rst = 1'b1;

    // No position ever captured: nothing lit, one tick per frame.
    tick_cnt = 0;
    window(320, 240, 0);
    window(0, 0, 0);
    boundary();
    window(320, 240, 0);
    chk("ticks_per_frame", 32'(tick_cnt), 32'd1);

    // First capture then boundary.
    tick(5, 5, 1, 320, 240);
    idle();
    boundary();
    window(320, 240, 49);

    // Mid-frame update waits for the next boundary.
    tick(330, 240, 1, 100, 100);
    window(320, 240, 49);
    window(100, 100, 0);
    boundary();
    window(100, 100, 49);
    window(320, 240, 0);

    // Last write wins, both acked.
    tick(200, 50, 1, 10, 10);
    tick(201, 50, 1, 50, 60);
    idle();
    boundary();
    window(10, 10, 0);
    window(50, 60, 49);

    // New position on the exact boundary cycle.
    tick(300, 300, 1, 30, 30);
    idle();
    boundary(1, 200, 200);
    window(30, 30, 49);
    window(200, 200, 0);
    boundary();
    window(200, 200, 49);

    // Edge clipping near the bottom-left corner.
    tick(100, 100, 1, 2, 478);
    boundary();
    window(2, 478, 31);

    // Randomized captures, including held pos_valid bursts.
    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        x = $urandom_range(0, 639);
        y = $urandom_range(0, 479);
        tick($urandom_range(0, 799), $urandom_range(0, 479), 1, x, y);
      end
      if ($urandom_range(0, 1) == 1) boundary(1, $urandom_range(0, 639), $urandom_range(0, 479));
      else boundary();
      window(x, y, -1);
      window(sx, sy, -1);
    end

    // Reset mid-line.
    for (int h = 300; h < 310; h++) tick(h, 240, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_pos_ack",    32'(pos_ack),    32'h0);
    chk("mid_rst_frame_tick", 32'(frame_tick), 32'h0);
    chk("mid_rst_ball_pix",   32'(ball_pix),   32'h0);
    chk("mid_rst_ball_rgb",   32'(ball_rgb),   32'h0);
    model_reset();
    @(negedge clk) rst = 1'b1;
    boundary();
    window(0, 0, 0);
    window(320, 240, 0);
    tick(10, 10, 1, 320, 240);
    boundary();
    window(320, 240, 49);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_renderer.md
# ball_renderer

Consumer side of the ball-position interface. Accepts the ball centre pixel from the ball tracker through a valid/ack handshake and holds it in a pending register. At each vertical-blank boundary it moves the pending position into a shadow register, so the ball never tears mid-frame. It compares the shadow position against the VGA scan counters through a 2-stage pipeline and drives a ball-pixel flag and colour into the display mux.

## Interface
- COORD_W, 10, width of x/y coordinates and scan counters
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- RADIUS, 4, ball radius in pixels; a pixel is lit when dx²+dy² ≤ RADIUS²
- BALL_RGB, 12'hFFF, colour driven on lit pixels

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- hcount  in  COORD_W  current scan column from VGA timing
- vcount  in  COORD_W  current scan line from VGA timing
- ball_x  in  COORD_W  ball centre column (unsigned)
- ball_y  in  COORD_W  ball centre line (unsigned)
- pos_valid  in  1  ball_x/ball_y are valid this cycle
- pos_ack  out  1  one-cycle pulse acknowledging the captured position
- frame_tick  out  1  one-cycle pulse at the frame boundary; ball tracker advances on it
- ball_pix  out  1  current pipelined pixel belongs to the ball
- ball_rgb  out  12  BALL_RGB when ball_pix is 1, else 0

## Operation
- State machine:
  - S_NOPOS: reset state; no position ever captured; ball_pix forced 0.
  - S_SHOW: shadow holds a valid position.
  - S_NOPOS → S_SHOW at the first frame boundary at which the pending register is full.
  - No return to S_NOPOS except through reset.
- Capture:
  - pos_valid=1 loads ball_x/ball_y into the pending register and sets pend_full.
  - pos_ack=1 on the next cycle.
  - A second pos_valid before the boundary overwrites pending (last write wins) and is still acked.
  - pos_valid held high for N cycles produces N acks.
- Frame boundary: the cycle with hcount==0 and vcount==V_ACTIVE.
  - frame_tick=1 for exactly that cycle.
  - If pend_full: shadow ← pending, pend_full ← 0.
  - Otherwise shadow keeps its old value.
- Simultaneous pos_valid and boundary:
  - Shadow takes the pending contents from before this cycle.
  - The new value lands in pending and is used next frame.
  - If pending was empty, shadow is unchanged.
- Arithmetic:
  - dx = hcount − shadow_x and dy = vcount − shadow_y, both signed COORD_W+1 bits.
  - Squares summed in 2·COORD_W+3 bits; no overflow, no wrap.
  - Off-screen or edge-partial balls clip naturally; only visible pixels are lit.
- Active qualifier: hcount < H_ACTIVE and vcount < V_ACTIVE, delayed alongside the data.

## Timing
- Pipeline:
  - Stage 1 registers dx, dy and active.
  - Stage 2 registers the compare result into ball_pix and ball_rgb.
  - Latency is 2 clk from hcount/vcount to ball_pix.
  - The pipeline advances every clk, no stall.
  - The VGA mux delays its sync signals by 2 to match.
- pos_ack: 1 clk after pos_valid.
- frame_tick: combinationally decoded, then registered; asserts 1 clk after the boundary counters are presented.
- Shadow update takes effect on the next frame's first visible pixel. Because the boundary falls in vertical blank, this is well before the first visible pixel.
- Reset (any time, including mid-frame):
  - pos_ack=0, frame_tick=0, ball_pix=0, ball_rgb=0.
  - pend_full=0, shadow=0, pipeline regs=0, state=S_NOPOS.

## Structure
- Shared package pong_pkg holds:
  - COORD_W, H_ACTIVE, V_ACTIVE
  - a coord_t typedef (logic [COORD_W-1:0])
  - the render_state_t enum {S_NOPOS, S_SHOW}
- These are shared with the ball tracker and the VGA timing block.
- One sub-module: ball_hit_pipe, containing the 2-stage dx/dy/square/compare datapath. The parent keeps the handshake, shadow and FSM.

## Test plan
- Reset, then scan a full frame with no pos_valid → ball_pix stays 0; frame_tick pulses once per frame; state remains S_NOPOS.
- pos_valid with (320,240), then a boundary, then the next frame → pos_ack 1 clk later. ball_pix=1 exactly at (hcount,vcount) = (320,240)+(±4,0) and (0,±4), each delayed 2 clk. (324,244) stays dark.
- Mid-frame pos_valid (100,100) while shadow=(320,240) → the rest of the current frame still draws at (320,240); the next frame draws at (100,100).
- Two pos_valid before one boundary, (10,10) then (50,60) → two acks; the next frame draws only at (50,60).
- pos_valid (200,200) on the exact boundary cycle with pending (30,30) → that frame draws (30,30); the following frame draws (200,200).
- Ball at (2,478) → only the in-range pixels light. Apply reset mid-line → all outputs are 0 on the next clk, and nothing is drawn until a new capture plus boundary.
